transmissor_resultado_serial: RTL and testbench
===============================================

TRANSMISSOR_RESULTADO_SERIAL -- requirements
Module: transmissor_resultado_serial

Interface
REQ-001 Parameter TICKS_POR_BIT, default 434, SHALL set the clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 Parameter LARGURA_TICKS, default 9, SHALL set the bit-timer width; it SHALL hold TICKS_POR_BIT-1.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 partida  input  1  SHALL request one result frame; sampled only in OCIOSO.
REQ-006 score  input  3  SHALL be the final score to report (0-7).
REQ-007 tempo  input  16  SHALL be the game-time value to report.
REQ-008 saida_serial  output  1  SHALL be the 8N1 serial line, idle high.
REQ-009 ocupado  output  1  SHALL be high while a frame is in progress.
REQ-010 pronto  output  1  SHALL be a one-cycle pulse marking frame completion.

Function
REQ-011 The frame SHALL be 10 bytes, in order: 0x53 'S', 0x30+score, 0x20, 0x54 'T', hex(tempo[15:12]), hex(tempo[11:8]), hex(tempo[7:4]), hex(tempo[3:0]), 0x0D, 0x0A.
REQ-012 Hex digit mapping SHALL be: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
REQ-013 Each byte SHALL be sent as a start bit (0), 8 data bits LSB first, and a stop bit (1), each lasting exactly TICKS_POR_BIT cycles.
REQ-014 Bytes SHALL be back-to-back with no idle gap; frame length SHALL be exactly 100*TICKS_POR_BIT cycles.
REQ-015 FSM states SHALL be OCIOSO, START, DADOS, STOP.
REQ-016 OCIOSO -> START on the edge where partida=1; the same edge SHALL capture score and tempo into internal registers and clear the byte and bit indexes.
REQ-017 START -> DADOS after TICKS_POR_BIT cycles; DADOS -> STOP after 8 bit periods; STOP -> START (next byte) when the byte index < 9, else STOP -> OCIOSO.
REQ-018 saida_serial, ocupado and pronto SHALL be registered; saida_serial SHALL go low and ocupado high in the cycle after partida is sampled (latency 1).
REQ-019 ocupado SHALL stay high for exactly 100*TICKS_POR_BIT cycles.
REQ-020 pronto SHALL be high for exactly the first cycle after ocupado falls.
REQ-021 partida while ocupado=1 SHALL be ignored and SHALL NOT be queued.
REQ-022 If partida is still high in the first OCIOSO cycle, a new frame SHALL start; the next frame's saida_serial low SHALL coincide with that cycle's pronto pulse plus one.
REQ-023 Changes to score or tempo after capture SHALL NOT affect the frame in progress.
REQ-024 saida_serial SHALL be 1 in OCIOSO and during every stop bit.

Reset
REQ-025 reset=0 SHALL immediately force state OCIOSO, saida_serial=1, ocupado=0, pronto=0, and clear all indexes, timers and captured registers.
REQ-026 reset asserted mid-frame SHALL abort the frame with no further bits emitted; after release, the next partida SHALL send a complete frame starting at byte 0.

Verification (TICKS_POR_BIT=4, LARGURA_TICKS=2)
REQ-027 Hold reset=0 with partida=1 -> saida_serial=1, ocupado=0, pronto=0 throughout.
REQ-028 score=5, tempo=0x1A3F, 1-cycle partida -> decoded bytes 53 35 20 54 31 41 33 46 0D 0A; ocupado high exactly 400 cycles; one pronto pulse.
REQ-029 score=0/tempo=0x0000 -> digit bytes 0x30 and 30 30 30 30; score=7/tempo=0xFFFF -> 0x37 and 46 46 46 46.
REQ-030 Pulse partida at cycle 50 of a frame and change score/tempo at cycle 60 -> single frame with the originally captured values; no second frame.
REQ-031 Assert reset during byte 4 -> saida_serial=1 and ocupado=0 in the same cycle; a new partida -> full 10-byte frame.
REQ-032 Hold partida=1 continuously -> two back-to-back frames, with one pronto pulse between them.

Source files
------------

// File: rtl/transmissor_resultado_serial.sv
// 8N1 serial transmitter for the end-of-game result frame "S<score> T<hhhh>\r\n".
// Outputs are registered from the next-state logic so they line up with the state register.
module transmissor_resultado_serial #(
  parameter int TICKS_POR_BIT = 434,
  parameter int LARGURA_TICKS = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [2:0]  score,
  input  logic [15:0] tempo,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto
);

  // state  | meaning
  // OCIOSO | line idle high, waiting for partida
  // START  | start bit (0) of the current byte
  // DADOS  | eight data bits, LSB first
  // STOP   | stop bit (1); then next byte or back to idle
  typedef enum logic [1:0] {OCIOSO, START, DADOS, STOP} estado_t;

  localparam logic [LARGURA_TICKS-1:0] TIMER_RECARGA = LARGURA_TICKS'(TICKS_POR_BIT - 1);
  localparam logic [3:0]               ULTIMO_BYTE   = 4'd9;

  estado_t                 estado_q, estado_d;
  logic [LARGURA_TICKS-1:0] timer_q, timer_d;
  logic [2:0]              bit_q, bit_d;
  logic [3:0]              byte_q, byte_d;
  logic [2:0]              score_q, score_d;
  logic [15:0]             tempo_q, tempo_d;
  logic                    saida_q, saida_d;
  logic                    ocupado_q, ocupado_d;
  logic                    pronto_q, pronto_d;
  logic [7:0]              byte_atual;
  logic                    timer_fim;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    else           return 8'h37 + {4'd0, n};
  endfunction

  always_comb begin
    byte_atual = 8'h0A;
    case (byte_q)
      4'd0: byte_atual = 8'h53;
      4'd1: byte_atual = 8'h30 + {5'd0, score_q};
      4'd2: byte_atual = 8'h20;
      4'd3: byte_atual = 8'h54;
      4'd4: byte_atual = hex_ascii(tempo_q[15:12]);
      4'd5: byte_atual = hex_ascii(tempo_q[11:8]);
      4'd6: byte_atual = hex_ascii(tempo_q[7:4]);
      4'd7: byte_atual = hex_ascii(tempo_q[3:0]);
      4'd8: byte_atual = 8'h0D;
      default: byte_atual = 8'h0A;
    endcase
  end

  assign timer_fim = (timer_q == '0);

  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    score_d  = score_q;
    tempo_d  = tempo_q;
    saida_d  = saida_q;
    pronto_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        saida_d = 1'b1;
        if (partida) begin
          estado_d = START;
          timer_d  = TIMER_RECARGA;
          bit_d    = 3'd0;
          byte_d   = 4'd0;
          score_d  = score;
          tempo_d  = tempo;
          saida_d  = 1'b0;
        end
      end
      START: begin
        if (timer_fim) begin
          estado_d = DADOS;
          timer_d  = TIMER_RECARGA;
          bit_d    = 3'd0;
          saida_d  = byte_atual[0];
        end else begin
          timer_d = timer_q - LARGURA_TICKS'(1);
        end
      end
      DADOS: begin
        if (timer_fim) begin
          timer_d = TIMER_RECARGA;
          if (bit_q == 3'd7) begin
            estado_d = STOP;
            saida_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            saida_d = byte_atual[bit_q + 3'd1];
          end
        end else begin
          timer_d = timer_q - LARGURA_TICKS'(1);
        end
      end
      STOP: begin
        if (timer_fim) begin
          if (byte_q < ULTIMO_BYTE) begin
            estado_d = START;
            timer_d  = TIMER_RECARGA;
            byte_d   = byte_q + 4'd1;
            saida_d  = 1'b0;
          end else begin
            // pronto lands in the first idle cycle, where partida can restart at once
            estado_d = OCIOSO;
            saida_d  = 1'b1;
            pronto_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - LARGURA_TICKS'(1);
        end
      end
      default: begin
        estado_d = OCIOSO;
        saida_d  = 1'b1;
      end
    endcase
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      timer_q   <= '0;
      bit_q     <= 3'd0;
      byte_q    <= 4'd0;
      score_q   <= 3'd0;
      tempo_q   <= 16'd0;
      saida_q   <= 1'b1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      score_q   <= score_d;
      tempo_q   <= tempo_d;
      saida_q   <= saida_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign saida_serial = saida_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;

endmodule

// File: tb/tb_transmissor_resultado_serial.sv
// Bench for transmissor_resultado_serial: compares the serial line, cycle by cycle,
// against a waveform built from the ASCII frame contents.
module tb_transmissor_resultado_serial;
  localparam int T  = 4;
  localparam int FB = 100 * T;

  logic        clock = 1'b0;
  logic        reset;
  logic        partida;
  logic [2:0]  score;
  logic [15:0] tempo;
  logic        saida_serial, ocupado, pronto;

  int tests = 0;
  int fails = 0;
  logic line [0:FB+8];
  int busy;

  transmissor_resultado_serial #(.TICKS_POR_BIT(T), .LARGURA_TICKS(2)) dut (
    .clock(clock), .reset(reset), .partida(partida), .score(score), .tempo(tempo),
    .saida_serial(saida_serial), .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] exp_byte(input int i, input logic [2:0] s, input logic [15:0] t);
    string hx;
    byte   b;
    hx = "0123456789ABCDEF";
    case (i)
      0: return 8'h53;
      1: return 8'h30 + {5'd0, s};
      2: return 8'h20;
      3: return 8'h54;
      4: begin b = hx[t[15:12]]; return b; end
      5: begin b = hx[t[11:8]];  return b; end
      6: begin b = hx[t[7:4]];   return b; end
      7: begin b = hx[t[3:0]];   return b; end
      8: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic logic exp_line(input int c, input logic [2:0] s, input logic [15:0] t);
    int bitn, pos;
    logic [7:0] v;
    bitn = c / T;
    pos  = bitn % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    v = exp_byte(bitn / 10, s, t);
    return v[pos-1];
  endfunction

  task automatic start_frame(input logic [2:0] s, input logic [15:0] t, input bit keep);
    score = s; tempo = t; partida = 1'b1;
    @(negedge clock);
    tests++;
    if (saida_serial !== 1'b0 || ocupado !== 1'b1) begin
      fails++;
      $display("FAIL start_latency saida=%b ocupado=%b required saida=0 ocupado=1", saida_serial, ocupado);
    end
    if (!keep) partida = 1'b0;
  endtask

  task automatic observe_frame(input bit disturb);
    int cyc;
    bit pr_bad;
    cyc = 0; pr_bad = 0;
    while (ocupado === 1'b1 && cyc < FB + 8) begin
      line[cyc] = saida_serial;
      if (pronto !== 1'b0) pr_bad = 1;
      if (disturb) begin
        if (cyc == 50) partida = 1'b1;
        else if (cyc == 51) partida = 1'b0;
        if (cyc == 60) begin score = 3'($urandom); tempo = 16'($urandom); end
      end
      cyc++;
      @(negedge clock);
    end
    busy = cyc;
    tests++;
    if (busy != FB) begin fails++; $display("FAIL busy_len got=%0d required=%0d", busy, FB); end
    tests++;
    if (pr_bad) begin fails++; $display("FAIL pronto_in_frame got=1 required=0"); end
    tests++;
    if (pronto !== 1'b1 || saida_serial !== 1'b1) begin
      fails++;
      $display("FAIL pronto_end pronto=%b saida=%b required 1 1", pronto, saida_serial);
    end
  endtask

  task automatic check_bytes(input string name, input logic [2:0] s, input logic [15:0] t);
    logic [7:0] got;
    bit ok;
    for (int by = 0; by < 10; by++) begin
      ok = 1;
      for (int c = by*10*T; c < (by+1)*10*T; c++)
        if (c >= busy || line[c] !== exp_line(c, s, t)) ok = 0;
      for (int k = 0; k < 8; k++) got[k] = line[(by*10 + 1 + k)*T + T/2];
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s byte%0d got=%h required=%h (bit timing or value)", name, by, got, exp_byte(by, s, t));
      end
    end
  endtask

  task automatic check_idle(input string name, input int n);
    bit bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (ocupado !== 1'b0 || saida_serial !== 1'b1 || pronto !== 1'b0) bad = 1;
      @(negedge clock);
    end
    tests++;
    if (bad) begin fails++; $display("FAIL %s ocupado=%b saida=%b pronto=%b required 0 1 0", name, ocupado, saida_serial, pronto); end
  endtask

  task automatic full_frame(input string name, input logic [2:0] s, input logic [15:0] t);
    start_frame(s, t, 0);
    observe_frame(0);
    check_bytes(name, s, t);
    @(negedge clock);
    check_idle({name, "_after"}, 3);
  endtask

  task automatic test_reset();
    reset = 1'b0; partida = 1'b1; score = 3'd5; tempo = 16'h1234;
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold saida=%b ocupado=%b pronto=%b required 1 0 0", saida_serial, ocupado, pronto);
      end
      @(negedge clock);
    end
    partida = 1'b0; reset = 1'b1;
    @(negedge clock);
    check_idle("idle_after_reset", 4);
  endtask

  task automatic test_frame_fixed();
    full_frame("fixed_5_1A3F", 3'd5, 16'h1A3F);
  endtask

  task automatic test_extremes();
    full_frame("min_0_0000", 3'd0, 16'h0000);
    full_frame("max_7_FFFF", 3'd7, 16'hFFFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) full_frame("random", 3'($urandom), 16'($urandom));
  endtask

  task automatic test_ignore_partida();
    logic [2:0] s; logic [15:0] t;
    s = 3'($urandom); t = 16'($urandom);
    start_frame(s, t, 0);
    observe_frame(1);
    check_bytes("no_requeue", s, t);
    @(negedge clock);
    check_idle("no_second_frame", 20);
  endtask

  task automatic test_reset_midframe();
    start_frame(3'($urandom), 16'($urandom), 0);
    repeat (170) @(negedge clock);
    reset = 1'b0;
    #1;
    tests++;
    if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort saida=%b ocupado=%b pronto=%b required 1 0 0", saida_serial, ocupado, pronto);
    end
    @(negedge clock);
    check_idle("reset_abort_hold", 10);
    reset = 1'b1;
    @(negedge clock);
    full_frame("after_reset", 3'($urandom), 16'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [2:0] s1, s2; logic [15:0] t1, t2;
    s1 = 3'($urandom); t1 = 16'($urandom);
    s2 = 3'($urandom); t2 = 16'($urandom);
    start_frame(s1, t1, 1);
    observe_frame(0);
    check_bytes("b2b_first", s1, t1);
    score = s2; tempo = t2;
    @(negedge clock);
    tests++;
    if (saida_serial !== 1'b0 || ocupado !== 1'b1 || pronto !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart saida=%b ocupado=%b pronto=%b required 0 1 0", saida_serial, ocupado, pronto);
    end
    partida = 1'b0;
    observe_frame(0);
    check_bytes("b2b_second", s2, t2);
    @(negedge clock);
    check_idle("b2b_after", 5);
  endtask

  initial begin
    test_reset();
    test_frame_fixed();
    test_extremes();
    test_random();
    test_ignore_partida();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
